// File: rtl/psola_playback_if.sv
// ----------------------------------------------------------------------------
// psola_playback_if
//
// Purpose: groups the frame hand-off from the PSOLA overlap-add stage and
// the audio-side playback outputs into one bundle.
//
// Signals:
//   frame_valid    one-cycle pulse, frame/frame_len valid this cycle
//   frame          completed overlap-add output array (Q FRAC_BITS)
//   frame_len      number of valid samples in frame
//   sample_tick    one-cycle sample-rate strobe
//   sample_out     current playback sample (saturated, signed)
//   sample_valid   pulses with each new sample_out
//   playing        high while a frame is being streamed
//   underrun_count ticks with no active frame after the first frame
//   overflow_count frames dropped because the pending bank was full
//
// Modports: master = producer / sample-clock side, slave = playback block.
// ----------------------------------------------------------------------------
interface psola_playback_if #(
    parameter int WINDOW_SIZE = 2048,
    parameter int OUT_WIDTH   = 16
);
    logic                        frame_valid;
    logic signed [31:0]          frame [2*WINDOW_SIZE];
    logic [11:0]                 frame_len;
    logic                        sample_tick;
    logic signed [OUT_WIDTH-1:0] sample_out;
    logic                        sample_valid;
    logic                        playing;
    logic [15:0]                 underrun_count;
    logic [15:0]                 overflow_count;

    modport master (
        output frame_valid, frame, frame_len, sample_tick,
        input  sample_out, sample_valid, playing, underrun_count, overflow_count
    );

    modport slave (
        input  frame_valid, frame, frame_len, sample_tick,
        output sample_out, sample_valid, playing, underrun_count, overflow_count
    );
endinterface

// File: rtl/psola_playback.sv
// ----------------------------------------------------------------------------
// psola_playback
//
// Purpose: captures each finished PSOLA output frame into a two-bank buffer
// and streams it out one sample per sample_tick, converting Q(FRAC_BITS)
// fixed point to saturated OUT_WIDTH audio. One bank is being played while
// the other holds the next frame, which hides frame-to-frame jitter.
// Underruns (idle ticks after the first frame) and dropped frames are
// counted with saturating counters.
//
// Ports:
//   clk_in  system clock
//   rst_in  asynchronous active-high reset
//   bus     psola_playback_if.slave (frame input, sample output, counters)
// ----------------------------------------------------------------------------
module psola_playback #(
    parameter int WINDOW_SIZE = 2048,
    parameter int FRAC_BITS   = 10,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    psola_playback_if.slave       bus
);

    localparam int DEPTH = 2 * WINDOW_SIZE;
    localparam int IDX_W = $clog2(DEPTH);
    // Lengths must hold DEPTH itself and the full 12-bit frame_len range.
    localparam int LEN_W = (($clog2(DEPTH) + 1) > 12) ? ($clog2(DEPTH) + 1) : 12;

    localparam logic signed [31:0] SAT_MAX = 32'sd2 ** (OUT_WIDTH - 1) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd2 ** (OUT_WIDTH - 1));

    typedef enum logic {IDLE, PLAY} state_t;

    state_t                 state_q, state_d;
    logic                   activeBank_q, activeBank_d;
    logic [LEN_W-1:0]       activeLen_q, activeLen_d;
    logic [LEN_W-1:0]       pendingLen_q, pendingLen_d;
    logic                   pendingValid_q, pendingValid_d;
    logic [LEN_W-1:0]       rdIdx_q, rdIdx_d;
    logic                   started_q, started_d;
    logic signed [OUT_WIDTH-1:0] sampleOut_q, sampleOut_d;
    logic                   sampleValid_q, sampleValid_d;
    logic [15:0]            underrun_q, underrun_d;
    logic [15:0]            overflow_q, overflow_d;

    logic signed [31:0]     bank_q [2][DEPTH];

    logic                   newFrame;
    logic                   captureEn;
    logic                   wrBank;
    logic [LEN_W-1:0]       frameLenExt;
    logic signed [31:0]     rdData;
    logic signed [31:0]     shifted;
    logic signed [OUT_WIDTH-1:0] satSample;

    // Zero-length frames are ignored entirely; a capture may only target the
    // inactive bank and only when no frame is already waiting there.
    assign newFrame    = bus.frame_valid && (bus.frame_len != 12'd0);
    assign captureEn   = newFrame && !pendingValid_q;
    assign wrBank      = ~activeBank_q;
    assign frameLenExt = LEN_W'(bus.frame_len);

    // Fixed-point to audio: floor shift then clamp to the output range.
    assign rdData  = bank_q[activeBank_q][rdIdx_q[IDX_W-1:0]];
    assign shifted = rdData >>> FRAC_BITS;

    always_comb begin
        satSample = shifted[OUT_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            satSample = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            satSample = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    // Bank storage has no reset; contents survive reset by design.
    always_ff @(posedge clk_in) begin
        if (captureEn) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[wrBank][i] <= bus.frame[i];
            end
        end
    end

    // Next-state logic. Capture/overflow bookkeeping is evaluated first and
    // is independent of the FSM; a promotion (which needs pendingValid_q=1)
    // can never coincide with a capture (which needs pendingValid_q=0).
    always_comb begin
        state_d        = state_q;
        activeBank_d   = activeBank_q;
        activeLen_d    = activeLen_q;
        pendingLen_d   = pendingLen_q;
        pendingValid_d = pendingValid_q;
        rdIdx_d        = rdIdx_q;
        started_d      = started_q;
        sampleOut_d    = sampleOut_q;
        sampleValid_d  = 1'b0;
        underrun_d     = underrun_q;
        overflow_d     = overflow_q;

        if (newFrame) begin
            if (pendingValid_q) begin
                if (overflow_q != 16'hFFFF) begin
                    overflow_d = overflow_q + 16'd1;
                end
            end else begin
                pendingValid_d = 1'b1;
                pendingLen_d   = (frameLenExt > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : frameLenExt;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.sample_tick) begin
                    sampleOut_d   = '0;
                    sampleValid_d = 1'b1;
                    if (started_q && (underrun_q != 16'hFFFF)) begin
                        underrun_d = underrun_q + 16'd1;
                    end
                end
                if (pendingValid_q) begin
                    state_d        = PLAY;
                    activeBank_d   = ~activeBank_q;
                    activeLen_d    = pendingLen_q;
                    pendingValid_d = 1'b0;
                    rdIdx_d        = '0;
                    started_d      = 1'b1;
                end
            end
            PLAY: begin
                if (bus.sample_tick) begin
                    sampleOut_d   = satSample;
                    sampleValid_d = 1'b1;
                    if (rdIdx_q == activeLen_q - LEN_W'(1)) begin
                        rdIdx_d = '0;
                        // Gapless hand-off when the next frame is already waiting.
                        if (pendingValid_q) begin
                            activeBank_d   = ~activeBank_q;
                            activeLen_d    = pendingLen_q;
                            pendingValid_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rdIdx_d = rdIdx_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            activeBank_q   <= 1'b0;
            activeLen_q    <= '0;
            pendingLen_q   <= '0;
            pendingValid_q <= 1'b0;
            rdIdx_q        <= '0;
            started_q      <= 1'b0;
            sampleOut_q    <= '0;
            sampleValid_q  <= 1'b0;
            underrun_q     <= '0;
            overflow_q     <= '0;
        end else begin
            state_q        <= state_d;
            activeBank_q   <= activeBank_d;
            activeLen_q    <= activeLen_d;
            pendingLen_q   <= pendingLen_d;
            pendingValid_q <= pendingValid_d;
            rdIdx_q        <= rdIdx_d;
            started_q      <= started_d;
            sampleOut_q    <= sampleOut_d;
            sampleValid_q  <= sampleValid_d;
            underrun_q     <= underrun_d;
            overflow_q     <= overflow_d;
        end
    end

    assign bus.sample_out     = sampleOut_q;
    assign bus.sample_valid   = sampleValid_q;
    assign bus.playing        = (state_q == PLAY);
    assign bus.underrun_count = underrun_q;
    assign bus.overflow_count = overflow_q;

endmodule

// File: tb/tb_psola_playback.sv
// ----------------------------------------------------------------------------
// tb_psola_playback
//
// Purpose: directed scoreboard bench for psola_playback. Every tick pushes
// its expected sample and the cycle it must appear in; a separate monitor
// pops and compares whenever sample_valid is seen. A small window (8-word
// banks) is used so the frame_len clamp can be exercised.
// ----------------------------------------------------------------------------
module tb_psola_playback;

    localparam int WIN   = 4;
    localparam int DEPTH = 2 * WIN;

    logic clock;
    logic reset;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int expUnder = 0;
    int expQ[$];
    int cycQ[$];
    int monExp;
    int monCyc;

    psola_playback_if #(.WINDOW_SIZE(WIN), .OUT_WIDTH(16)) bus ();

    psola_playback #(
        .WINDOW_SIZE(WIN),
        .FRAC_BITS  (10),
        .OUT_WIDTH  (16)
    ) dut (
        .clk_in(clock),
        .rst_in(reset),
        .bus   (bus.slave)
    );

    // 10 ns clock and free-running cycle counter.
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Present one frame pulse with up to four leading samples (rest zero).
    task automatic applyStimulus(input int len, input int a, input int b, input int c, input int d);
        @(posedge clock);
        #1;
        for (int i = 0; i < DEPTH; i++) bus.frame[i] = 32'sd0;
        bus.frame[0] = a;
        bus.frame[1] = b;
        bus.frame[2] = c;
        bus.frame[3] = d;
        bus.frame_len   = 12'(len);
        bus.frame_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.frame_valid = 1'b0;
    endtask

    // One tick; the matching sample must show up at the next clock edge.
    task automatic doTick(input int expected);
        @(posedge clock);
        #1;
        bus.sample_tick = 1'b1;
        expQ.push_back(expected);
        cycQ.push_back(cyc + 1);
        @(posedge clock);
        #1;
        bus.sample_tick = 1'b0;
    endtask

    // Tick and frame pulse in the same cycle.
    task automatic tickWithFrame(input int expected, input int len, input int a, input int b);
        @(posedge clock);
        #1;
        for (int i = 0; i < DEPTH; i++) bus.frame[i] = 32'sd0;
        bus.frame[0]    = a;
        bus.frame[1]    = b;
        bus.frame_len   = 12'(len);
        bus.frame_valid = 1'b1;
        bus.sample_tick = 1'b1;
        expQ.push_back(expected);
        cycQ.push_back(cyc + 1);
        @(posedge clock);
        #1;
        bus.frame_valid = 1'b0;
        bus.sample_tick = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: compare every presented sample against the scoreboard.
    always @(negedge clock) begin
        if (!reset && bus.sample_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_sample actual=%0d required=none", bus.sample_out);
            end else begin
                monExp = expQ.pop_front();
                monCyc = cycQ.pop_front();
                checkOutput("sample_out", int'(bus.sample_out), monExp);
                checkOutput("sample_latency_cycle", cyc, monCyc);
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.frame_valid = 1'b0;
        bus.frame_len   = 12'd0;
        bus.sample_tick = 1'b0;
        for (int i = 0; i < DEPTH; i++) bus.frame[i] = 32'sd0;

        waitCycles(3);
        checkOutput("reset_sample_out", int'(bus.sample_out), 0);
        checkOutput("reset_sample_valid", int'(bus.sample_valid), 0);
        checkOutput("reset_playing", int'(bus.playing), 0);
        checkOutput("reset_underrun", int'(bus.underrun_count), 0);
        checkOutput("reset_overflow", int'(bus.overflow_count), 0);
        reset = 1'b0;
        waitCycles(2);

        $display("[TB] basic playback");
        applyStimulus(4, 1024, -2048, 5120, 0);
        waitCycles(2);
        checkOutput("basic_playing", int'(bus.playing), 1);
        doTick(1);  waitCycles(8);
        doTick(-2); waitCycles(8);
        doTick(5);  waitCycles(8);
        doTick(0);  waitCycles(2);
        checkOutput("basic_idle_playing", int'(bus.playing), 0);
        doTick(0);
        expUnder = 1;
        checkOutput("basic_underrun", int'(bus.underrun_count), expUnder);

        $display("[TB] saturation");
        applyStimulus(3, 32'h7FFFFFFF, 32'h80000000, -1, 0);
        waitCycles(2);
        doTick(32767);
        doTick(-32768);
        doTick(-1);
        waitCycles(2);
        checkOutput("sat_idle_playing", int'(bus.playing), 0);

        $display("[TB] gapless handoff");
        applyStimulus(3, 1024, 2048, 3072, 0);
        waitCycles(2);
        doTick(1);
        applyStimulus(2, 7168, 8192, 0, 0);
        doTick(2);
        doTick(3);
        doTick(7);
        doTick(8);
        waitCycles(2);
        checkOutput("gapless_underrun", int'(bus.underrun_count), expUnder);

        $display("[TB] overflow");
        applyStimulus(1, 1024, 0, 0, 0);
        applyStimulus(2, 2048, 3072, 0, 0);
        applyStimulus(1, 4096, 0, 0, 0);
        checkOutput("overflow_count", int'(bus.overflow_count), 1);
        applyStimulus(0, 9999 * 1024, 0, 0, 0);
        checkOutput("overflow_len0", int'(bus.overflow_count), 1);
        checkOutput("overflow_playing", int'(bus.playing), 1);
        doTick(1);
        doTick(2);
        doTick(3);
        waitCycles(2);
        checkOutput("overflow_idle_playing", int'(bus.playing), 0);

        $display("[TB] simultaneous end and arrival");
        applyStimulus(2, 1024, 2048, 0, 0);
        waitCycles(2);
        doTick(1);
        tickWithFrame(2, 2, 5120, 6144);
        waitCycles(2);
        checkOutput("simul_playing", int'(bus.playing), 1);
        doTick(5);
        doTick(6);
        checkOutput("simul_underrun", int'(bus.underrun_count), expUnder);

        $display("[TB] frame_len clamp");
        @(posedge clock);
        #1;
        for (int i = 0; i < DEPTH; i++) bus.frame[i] = 1024 * (i + 1);
        bus.frame_len   = 12'd10;
        bus.frame_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.frame_valid = 1'b0;
        waitCycles(2);
        for (int i = 0; i < DEPTH; i++) doTick(i + 1);
        doTick(0);
        expUnder = expUnder + 1;
        checkOutput("clamp_underrun", int'(bus.underrun_count), expUnder);

        $display("[TB] async reset mid-play");
        applyStimulus(4, 1024, 2048, 3072, 4096);
        waitCycles(2);
        doTick(1);
        doTick(2);
        applyStimulus(1, -1024, 0, 0, 0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("arst_sample_out", int'(bus.sample_out), 0);
        checkOutput("arst_playing", int'(bus.playing), 0);
        checkOutput("arst_underrun", int'(bus.underrun_count), 0);
        checkOutput("arst_overflow", int'(bus.overflow_count), 0);
        waitCycles(2);
        reset = 1'b0;
        expUnder = 0;
        waitCycles(2);
        doTick(0);
        checkOutput("arst_no_started_underrun", int'(bus.underrun_count), 0);
        checkOutput("arst_pending_discarded", int'(bus.playing), 0);
        applyStimulus(2, 9216, 10240, 0, 0);
        waitCycles(2);
        doTick(9);
        doTick(10);
        doTick(0);
        checkOutput("arst_underrun_after", int'(bus.underrun_count), 1);

        waitCycles(4);
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
